// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that keeps its storage in an external synchronous RAM and
// fronts it with a 2-entry first-word-fall-through output buffer.
module ram_fifo_ctrl #(
  parameter int unsigned AW        = 9,
  parameter int unsigned DW        = 32,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned AE_MARGIN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW+1:0] level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow
);

  localparam logic [AW:0]   DEPTH_W = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   AF_W    = (AW+1)'(AF_MARGIN);
  localparam logic [AW+1:0] AE_W    = (AW+2)'(AE_MARGIN);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic          ob_head_q, ob_head_d;
  logic          rd_pending_q, rd_pending_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] ob_mem_q [2];
  logic [DW-1:0] ob_mem_d [2];

  logic          push_fire_s;
  logic          pop_fire_s;
  logic [2:0]    ob_occ_s;
  logic [AW:0]   free_s;

  // Handshakes, RAM port drive and status flags, all from registered state.
  always_comb begin
    full         = (ram_cnt_q == DEPTH_W);
    push_ready   = !full && !flush && !rst;
    push_fire_s  = push_valid && push_ready;
    pop_valid    = (ob_cnt_q != 2'd0);
    pop_fire_s   = pop_valid && pop_ready;
    pop_data     = ob_mem_q[ob_head_q];
    // Buffer slots still claimed after this cycle, counting the read in flight.
    ob_occ_s     = 3'(ob_cnt_q) + 3'(rd_pending_q) - 3'(pop_fire_s);
    ram_ren      = (ram_cnt_q != {(AW+1){1'b0}}) && (ob_occ_s < 3'd2) && !flush && !rst;
    ram_raddr    = rptr_q;
    ram_wen      = push_fire_s;
    ram_waddr    = wptr_q;
    ram_wdata    = push_data;
    level        = (AW+2)'(ram_cnt_q) + (AW+2)'(rd_pending_q) + (AW+2)'(ob_cnt_q);
    free_s       = DEPTH_W - ram_cnt_q;
    empty        = (level == {(AW+2){1'b0}});
    almost_full  = (free_s <= AF_W);
    almost_empty = (level <= AE_W);
    overflow     = overflow_q;
  end

  // Next-state: pointers, RAM occupancy, read pipeline and output buffer.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    ram_cnt_d    = ram_cnt_q;
    ob_cnt_d     = ob_cnt_q;
    ob_head_d    = ob_head_q;
    rd_pending_d = rd_pending_q;
    overflow_d   = overflow_q;
    ob_mem_d     = ob_mem_q;
    if (flush) begin
      wptr_d       = {AW{1'b0}};
      rptr_d       = {AW{1'b0}};
      ram_cnt_d    = {(AW+1){1'b0}};
      ob_cnt_d     = 2'd0;
      ob_head_d    = 1'b0;
      rd_pending_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      wptr_d       = push_fire_s ? wptr_q + AW'(1) : wptr_q;
      rptr_d       = ram_ren ? rptr_q + AW'(1) : rptr_q;
      ram_cnt_d    = ram_cnt_q + (AW+1)'(push_fire_s) - (AW+1)'(ram_ren);
      rd_pending_d = ram_ren;
      ob_cnt_d     = ob_cnt_q + 2'(rd_pending_q) - 2'(pop_fire_s);
      ob_head_d    = pop_fire_s ? ~ob_head_q : ob_head_q;
      overflow_d   = overflow_q || (push_valid && full);
      // A returning read never finds the buffer full, so the tail slot is free.
      if (rd_pending_q) begin
        ob_mem_d[ob_head_q ^ ob_cnt_q[0]] = ram_rdata;
      end else begin
        ob_mem_d = ob_mem_q;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= {AW{1'b0}};
      rptr_q       <= {AW{1'b0}};
      ram_cnt_q    <= {(AW+1){1'b0}};
      ob_cnt_q     <= 2'd0;
      ob_head_q    <= 1'b0;
      rd_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
      ob_mem_q[0]  <= {DW{1'b0}};
      ob_mem_q[1]  <= {DW{1'b0}};
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      ram_cnt_q    <= ram_cnt_d;
      ob_cnt_q     <= ob_cnt_d;
      ob_head_q    <= ob_head_d;
      rd_pending_q <= rd_pending_d;
      overflow_q   <= overflow_d;
      ob_mem_q[0]  <= ob_mem_d[0];
      ob_mem_q[1]  <= ob_mem_d[1];
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl (AW=4): queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          push_valid, push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid, pop_ready;
  logic [DW-1:0] pop_data;
  logic          ram_wen, ram_ren;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [AW+1:0] level;
  logic          full, empty, almost_full, almost_empty, overflow;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.AW(AW), .DW(DW), .AF_MARGIN(4), .AE_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .level(level), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow)
  );

  // Synchronous RAM: read data valid only in the cycle after the read, junk otherwise.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_wen === 1'b1) ram_mem[ram_waddr] <= ram_wdata;
    if (ram_ren === 1'b1) ram_rdata <= ram_mem[ram_raddr];
    else                  ram_rdata <= 32'hDEAD_BEEF;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;
  int pops_n = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] mq [$];
  int            ms [$];
  int            sz;
  bit            epv;
  logic [DW-1:0] seq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: contents are a queue; each word becomes visible two edges after acceptance.
  always @(negedge clk) begin
    if (chk_en) begin
      sz  = mq.size();
      epv = 1'b0;
      if (sz != 0) epv = ((edge_n - ms[0]) >= 2);
      chk("m_level", 64'(level), 64'(sz));
      chk("m_pop_valid", 64'(pop_valid), 64'(epv));
      if (epv) chk("m_pop_data", 64'(pop_data), 64'(mq[0]));
      chk("m_empty", 64'(empty), 64'(sz == 0));
      chk("m_almost_empty", 64'(almost_empty), 64'(sz <= 2));
      if (rst || flush)  chk("m_push_ready", 64'(push_ready), 64'(0));
      else if (sz < 16)  chk("m_push_ready", 64'(push_ready), 64'(1));
      else if (sz == 18) chk("m_push_ready", 64'(push_ready), 64'(0));
      if (sz < 16)       chk("m_full", 64'(full), 64'(0));
      else if (sz == 18) chk("m_full", 64'(full), 64'(1));
      if (sz < 12)       chk("m_almost_full", 64'(almost_full), 64'(0));
      else if (sz >= 14) chk("m_almost_full", 64'(almost_full), 64'(1));
      if (rst || flush) begin
        mq.delete();
        ms.delete();
      end else begin
        if (epv && pop_ready) begin
          void'(mq.pop_front());
          void'(ms.pop_front());
          pops_n++;
        end
        if (push_valid && push_ready) begin
          mq.push_back(push_data);
          ms.push_back(edge_n + 1);
        end
      end
    end
    edge_n++;
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_push_ready"},   64'(push_ready),   64'(1));
    chk({tag, "_pop_valid"},    64'(pop_valid),    64'(0));
    chk({tag, "_level"},        64'(level),        64'(0));
    chk({tag, "_empty"},        64'(empty),        64'(1));
    chk({tag, "_almost_empty"}, 64'(almost_empty), 64'(1));
    chk({tag, "_full"},         64'(full),         64'(0));
    chk({tag, "_almost_full"},  64'(almost_full),  64'(0));
    chk({tag, "_overflow"},     64'(overflow),     64'(0));
    chk({tag, "_ram_wen"},      64'(ram_wen),      64'(0));
    chk({tag, "_ram_ren"},      64'(ram_ren),      64'(0));
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_data  = seq;
      seq        = seq + 32'd1;
      step();
    end
    push_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, acc, maxl, guard;
    bit a;
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    seq = 32'h1000_0000;
    step(); step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk_reset_state("reset");
    step();

    // Single word: level 1,1,1,0 and pop_valid from the second edge.
    pop_ready = 1'b1; push_valid = 1'b1; push_data = 32'h0000_00A5;
    step();
    push_valid = 1'b0;
    chk("sw_level_k", 64'(level), 64'(1));
    chk("sw_pv_k", 64'(pop_valid), 64'(0));
    step();
    chk("sw_level_k1", 64'(level), 64'(1));
    chk("sw_pv_k1", 64'(pop_valid), 64'(0));
    step();
    chk("sw_level_k2", 64'(level), 64'(1));
    chk("sw_pv_k2", 64'(pop_valid), 64'(1));
    chk("sw_data_k2", 64'(pop_data), 64'h0000_00A5);
    step();
    chk("sw_level_k3", 64'(level), 64'(0));

    // Fill with pop_ready low, then overflow.
    pop_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_valid = 1'b1; push_data = seq; seq = seq + 32'd1;
      step();
    end
    chk("fill16_level", 64'(level), 64'(16));
    chk("fill16_push_ready", 64'(push_ready), 64'(1));
    chk("fill16_full", 64'(full), 64'(0));
    chk("fill16_almost_full", 64'(almost_full), 64'(1));
    for (int i = 0; i < 2; i++) begin
      push_valid = 1'b1; push_data = seq; seq = seq + 32'd1;
      step();
    end
    chk("fill18_level", 64'(level), 64'(18));
    chk("fill18_full", 64'(full), 64'(1));
    chk("fill18_push_ready", 64'(push_ready), 64'(0));
    chk("fill18_overflow", 64'(overflow), 64'(0));
    step();
    chk("ovf_overflow", 64'(overflow), 64'(1));
    chk("ovf_level", 64'(level), 64'(18));

    // Reset with a full buffer and a push pending.
    rst = 1'b1; push_valid = 1'b1; push_data = 32'h0BAD_0BAD;
    step();
    rst = 1'b0; push_valid = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    step();

    // Streaming: 100 words, one per cycle, three in flight at steady state.
    pop_ready = 1'b1;
    p0 = pops_n;
    for (int i = 0; i < 100; i++) begin
      push_valid = 1'b1; push_data = seq; seq = seq + 32'd1;
      step();
      if (i >= 2) begin
        chk("stream_level", 64'(level), 64'(3));
        chk("stream_pop_valid", 64'(pop_valid), 64'(1));
      end
    end
    push_valid = 1'b0;
    repeat (4) step();
    chk("stream_pops", 64'(pops_n - p0), 64'(100));
    chk("stream_level_end", 64'(level), 64'(0));

    // Backpressure: continuous push, pop_ready about 30% of cycles.
    p0 = pops_n; acc = 0; maxl = 0;
    for (int i = 0; i < 300; i++) begin
      pop_ready  = ($urandom_range(0, 99) < 30);
      push_valid = 1'b1;
      push_data  = seq;
      a = push_ready;
      step();
      if (a) begin
        acc++;
        seq = seq + 32'd1;
      end
      if (int'(level) > maxl) maxl = int'(level);
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    chk("bp_max_level", 64'(maxl), 64'(18));
    guard = 0;
    while (level != '0 && guard < 40) begin
      step();
      guard++;
    end
    chk("bp_drain_level", 64'(level), 64'(0));
    chk("bp_pops_eq_pushes", 64'(pops_n - p0), 64'(acc));

    // Overflow then flush.
    pop_ready = 1'b0;
    push_n(19);
    chk("fovf_overflow", 64'(overflow), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fovf_overflow_clr", 64'(overflow), 64'(0));
    chk("fovf_level", 64'(level), 64'(0));
    chk("fovf_push_ready", 64'(push_ready), 64'(1));
    step();

    // Flush with a RAM read in flight and five words held.
    push_n(5);
    repeat (3) step();
    chk("fl_level5", 64'(level), 64'(5));
    push_valid = 1'b1; push_data = seq; seq = seq + 32'd1; pop_ready = 1'b1;
    #1;
    chk("fl_ram_ren", 64'(ram_ren), 64'(1));
    step();
    chk("fl_level_inflight", 64'(level), 64'(5));
    flush = 1'b1; push_valid = 1'b1; push_data = seq; pop_ready = 1'b1;
    step();
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    #1;
    chk("fl_level0", 64'(level), 64'(0));
    chk("fl_pop_valid", 64'(pop_valid), 64'(0));
    chk("fl_overflow", 64'(overflow), 64'(0));
    chk("fl_empty", 64'(empty), 64'(1));
    repeat (2) step();
    chk("fl_no_ghost_pv", 64'(pop_valid), 64'(0));
    chk("fl_no_ghost_level", 64'(level), 64'(0));
    pop_ready = 1'b1; push_valid = 1'b1; push_data = 32'h0000_0011;
    step();
    push_valid = 1'b0;
    step(); step();
    chk("fl_after_pv", 64'(pop_valid), 64'(1));
    chk("fl_after_data", 64'(pop_data), 64'h0000_0011);
    step();
    chk("fl_after_level", 64'(level), 64'(0));

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
